// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link transmit/receive ends: FSM state
// codes and serial line levels.
package serial_tx_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Parallel word handshake into the serial transmitter (valid/ready).
interface serial_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/serial_tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period; tick_nxt_c is the value tick will take after the next edge.
module serial_tx_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_nxt_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clear || (cnt == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
    tick_nxt_c = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      tick <= tick_nxt_c;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out frame transmitter: start, WIDTH data bits LSB first,
// optional even parity (define SERIAL_TX_PARITY_EN), stop.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  serial_tx_if.slave  link,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             ready_q;
  logic             tx_d, busy_d, done_d, ready_d;
  logic             tick, tick_nxt_c;
  logic             accept_c;
  logic             baud_clear_c;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_d;
`endif

  assign accept_c      = link.in_valid & ready_q;
  assign link.in_ready = ready_q;
  assign baud_clear_c  = (state == S_IDLE);

  serial_tx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear      (baud_clear_c),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  // Next state plus next values of the output registers, decoded from the
  // state being entered so every port is driven straight from a flop.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
`ifdef SERIAL_TX_PARITY_EN
    par_d     = par;
`endif
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_START;
          shreg_d = link.in_data;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^link.in_data;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            shreg_d   = shreg >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          // In the last stop cycle a new word starts the next frame directly.
          if (accept_c) begin
            state_d = S_START;
            shreg_d = link.in_data;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^link.in_data;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d  = (state_d == S_STOP) && tick_nxt_c;
    ready_d = (state_d == S_IDLE) || done_d;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = START_BIT;
      S_DATA:   tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = STOP_BIT;
      default:  tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
      ready_q <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

endmodule
